// File: rtl/val2_shift_sequencer.sv
// Iterative Val2 generator for the EXE stage: one single-step shifter/rotator
// run for N cycles under a start/busy/done handshake.
module val2_shift_sequencer #(
  parameter int DATA_W   = 32,
  parameter int ROT_STEP = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic [DATA_W-1:0] rm_val,
  input  logic              imm,
  input  logic              ld_or_str,
  input  logic [11:0]       shift_operand,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] work, load_val, step_val;
  logic [4:0]        cnt, load_cnt;
  logic [1:0]        sh_type, load_type;
  logic              rot_mode, load_rot;
  logic              accept;

  assign accept = (state == IDLE) && start && !flush;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  // Operand decode; ld_or_str takes priority over imm, unsupported forms load zero.
  always_comb begin
    load_val  = '0;
    load_cnt  = '0;
    load_type = 2'b00;
    load_rot  = 1'b0;
    if (ld_or_str) begin
      load_val = {{(DATA_W-12){shift_operand[11]}}, shift_operand};
    end else if (imm) begin
      load_val = {{(DATA_W-8){shift_operand[7]}}, shift_operand[7:0]};
      load_cnt = {1'b0, shift_operand[11:8]};
      load_rot = 1'b1;
    end else if (!shift_operand[4]) begin
      load_val  = rm_val;
      load_cnt  = shift_operand[11:7];
      load_type = shift_operand[6:5];
    end
  end

  always_comb begin
    step_val = work;
    if (rot_mode) begin
      step_val = {work[ROT_STEP-1:0], work[DATA_W-1:ROT_STEP]};
    end else begin
      case (sh_type)
        2'b00:   step_val = {work[DATA_W-2:0], 1'b0};
        2'b01:   step_val = {1'b0, work[DATA_W-1:1]};
        2'b10:   step_val = {work[DATA_W-1], work[DATA_W-1:1]};
        default: step_val = {work[0], work[DATA_W-1:1]};
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (load_cnt == '0) ? DONE : SHIFT;
      SHIFT:   if (flush) state_nxt = IDLE;
               else if (cnt == 5'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // result is written on whichever edge enters DONE: the accept edge when N=0,
  // otherwise the edge applying the last step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work     <= '0;
      cnt      <= '0;
      sh_type  <= 2'b00;
      rot_mode <= 1'b0;
      result   <= '0;
    end else if (accept) begin
      work     <= load_val;
      cnt      <= load_cnt;
      sh_type  <= load_type;
      rot_mode <= load_rot;
      if (load_cnt == '0) result <= load_val;
    end else if (state == SHIFT && !flush && cnt != '0) begin
      work <= step_val;
      cnt  <= cnt - 5'd1;
      if (cnt == 5'd1) result <= step_val;
    end
  end

endmodule
